// File: rtl/ttl_serial_frame_receiver.sv
// Serial frame receiver: start bit, DATA_WIDTH data bits LSB-first, stop bit.
// Presents each good word on Q with a VALID/READY handshake and sticky FE/OVR flags.
module ttl_serial_frame_receiver #(
    parameter int DATA_WIDTH = 4
) (
    input  logic                  CP,
    input  logic                  MR_n,
    input  logic                  EN,
    input  logic                  SI,
    input  logic                  READY,
    input  logic                  CLR_ERR,
    output logic [DATA_WIDTH-1:0] Q,
    output logic                  VALID,
    output logic                  BUSY,
    output logic                  FE,
    output logic                  OVR
);

    localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        STOP,
        BRK
    } state_t;

    state_t                state_q;
    logic [DATA_WIDTH-1:0] sr_q;
    logic [CW-1:0]         cnt_q;
    logic [DATA_WIDTH-1:0] q_q;
    logic                  valid_q;
    logic                  fe_q;
    logic                  ovr_q;

    always_ff @(posedge CP or negedge MR_n) begin
        if (!MR_n) begin
            state_q <= IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
            q_q     <= '0;
            valid_q <= 1'b0;
            fe_q    <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            // Later assignments below override these, so new errors and
            // new words win over clears and consumption on the same edge.
            if (CLR_ERR) begin
                fe_q  <= 1'b0;
                ovr_q <= 1'b0;
            end
            if (valid_q && READY) begin
                valid_q <= 1'b0;
            end
            if (EN) begin
                unique case (state_q)
                    IDLE: begin
                        if (!SI) begin
                            state_q <= DATA;
                            cnt_q   <= '0;
                        end
                    end
                    DATA: begin
                        sr_q <= {SI, sr_q[DATA_WIDTH-1:1]};
                        if (cnt_q == CW'(DATA_WIDTH - 1)) begin
                            state_q <= STOP;
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                    STOP: begin
                        if (SI) begin
                            state_q <= IDLE;
                            if (!valid_q || READY) begin
                                q_q     <= sr_q;
                                valid_q <= 1'b1;
                            end else begin
                                ovr_q <= 1'b1;
                            end
                        end else begin
                            state_q <= BRK;
                            fe_q    <= 1'b1;
                        end
                    end
                    BRK: begin
                        if (SI) begin
                            state_q <= IDLE;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign Q     = q_q;
    assign VALID = valid_q;
    assign BUSY  = (state_q == DATA) || (state_q == STOP);
    assign FE    = fe_q;
    assign OVR   = ovr_q;

endmodule
